// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined operand-2 shifter: shift types, IR class codes,
// IR field positions and the decoded-operand payload carried between pipeline stages.
package shifter_pkg;

  localparam int unsigned MAX_WIDTH = 64;
  localparam int unsigned AMT_W     = 8;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam logic [2:0] CLS_REG = 3'b000;
  localparam logic [2:0] CLS_IMM = 3'b001;

  localparam int unsigned IR_CLS_HI  = 27;
  localparam int unsigned IR_CLS_LO  = 25;
  localparam int unsigned IR_AMT_HI  = 11;
  localparam int unsigned IR_AMT_LO  = 7;
  localparam int unsigned IR_TYPE_HI = 6;
  localparam int unsigned IR_TYPE_LO = 5;
  localparam int unsigned IR_REG_SH  = 4;
  localparam int unsigned IR_ROT_HI  = 11;
  localparam int unsigned IR_ROT_LO  = 8;
  localparam int unsigned IR_IMM_HI  = 7;

  // amt already has the "imm #0 means W" substitution applied by the decoder
  typedef struct packed {
    logic [MAX_WIDTH-1:0] val;
    logic [AMT_W-1:0]     amt;
    logic [1:0]           stype;
    logic                 imm_form;
    logic                 rrx;
    logic                 bypass;
  } dec_op_t;

endpackage

// File: rtl/shift_core.sv
// Combinational log2(WIDTH)-level barrel shifter with shifter carry-out.
// LSL is done as a right shift of the bit-reversed operand so all types share one carry rule.
module shift_core
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] val,
  input  logic [AMT_W-1:0] amt,
  input  logic [1:0]       stype,
  input  logic             rrx,
  input  logic             carry_in,
  output logic [WIDTH-1:0] data_c,
  output logic             carry_c
);

  localparam int unsigned      LOG2W     = $clog2(WIDTH);
  localparam logic [AMT_W-1:0] WIDTH_AMT = AMT_W'(WIDTH);
  localparam logic [WIDTH-1:0] ONES      = '1;

  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] shf;
  logic [WIDTH-1:0] shf_rev;
  logic [LOG2W-1:0] sh;
  logic             fill;
  logic             is_lsl;
  logic             is_asr;

  always_comb begin
    is_lsl = (stype == SH_LSL);
    is_asr = (stype == SH_ASR);
    sh     = amt[LOG2W-1:0];
    fill   = is_asr & val[WIDTH-1];
    src    = val;
    if (is_lsl) begin
      for (int unsigned i = 0; i < WIDTH; i++) src[i] = val[WIDTH-1-i];
    end
    shf = src;
    for (int unsigned k = 0; k < LOG2W; k++) begin
      if (sh[k]) begin
        if (stype == SH_ROR) shf = (shf >> (1 << k)) | (shf << (WIDTH - (1 << k)));
        else                 shf = (shf >> (1 << k)) | (fill ? ~(ONES >> (1 << k)) : '0);
      end
    end
    shf_rev = shf;
    for (int unsigned i = 0; i < WIDTH; i++) shf_rev[i] = shf[WIDTH-1-i];
  end

  // Range handling: amount 0 passes through, amounts at or beyond WIDTH saturate.
  always_comb begin
    data_c  = val;
    carry_c = carry_in;
    if (rrx) begin
      data_c  = {carry_in, val[WIDTH-1:1]};
      carry_c = val[0];
    end else if (amt != '0) begin
      if (stype == SH_ROR) begin
        data_c  = shf;
        carry_c = (sh == '0) ? val[WIDTH-1] : val[sh - LOG2W'(1)];
      end else if (amt < WIDTH_AMT) begin
        data_c  = is_lsl ? shf_rev : shf;
        carry_c = src[sh - LOG2W'(1)];
      end else if (amt == WIDTH_AMT) begin
        data_c  = is_asr ? {WIDTH{val[WIDTH-1]}} : '0;
        carry_c = is_lsl ? val[0] : val[WIDTH-1];
      end else begin
        data_c  = is_asr ? {WIDTH{val[WIDTH-1]}} : '0;
        carry_c = is_asr & val[WIDTH-1];
      end
    end
  end

endmodule

// File: rtl/pipelined_operand_shifter.sv
// Pipelined data-processing operand-2 shifter: IR decode, then barrel shift + carry, valid/ready both sides.
// Build option SHIFTER_RRX_EN: imm-form ROR #0 performs RRX instead of passing Rm through.
module pipelined_operand_shifter
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_ir,
  input  logic [WIDTH-1:0] in_rm,
  input  logic [WIDTH-1:0] in_rs,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_bypass
);

`ifdef SHIFTER_RRX_EN
  localparam bit RRX_EN = 1'b1;
`else
  localparam bit RRX_EN = 1'b0;
`endif

  localparam logic [AMT_W-1:0] WIDTH_AMT = AMT_W'(WIDTH);

  dec_op_t          dec_c;
  dec_op_t          core_op;
  logic             core_carry_in;
  logic             core_valid;
  logic             out_adv;
  logic [WIDTH-1:0] core_data_c;
  logic             core_carry_c;
  logic             unused_c;

  assign out_adv  = !out_valid || out_ready;
  assign unused_c = ^{in_ir[31:28], in_ir[24:12], in_rs, core_op};

  // Operand decode; non-shifter classes become a zero-amount passthrough flagged as bypass.
  always_comb begin
    dec_c     = '0;
    dec_c.val = MAX_WIDTH'(in_rm);
    if (in_ir[IR_CLS_HI:IR_CLS_LO] == CLS_REG) begin
      dec_c.stype = in_ir[IR_TYPE_HI:IR_TYPE_LO];
      if (in_ir[IR_REG_SH]) begin
        dec_c.amt = in_rs[AMT_W-1:0];
      end else begin
        dec_c.imm_form = 1'b1;
        dec_c.amt      = AMT_W'(in_ir[IR_AMT_HI:IR_AMT_LO]);
        if (in_ir[IR_AMT_HI:IR_AMT_LO] == 5'd0) begin
          if (dec_c.stype == SH_LSR || dec_c.stype == SH_ASR) dec_c.amt = WIDTH_AMT;
          else if (dec_c.stype == SH_ROR)                      dec_c.rrx = RRX_EN;
        end
      end
    end else if (in_ir[IR_CLS_HI:IR_CLS_LO] == CLS_IMM) begin
      dec_c.val   = MAX_WIDTH'(in_ir[IR_IMM_HI:0]);
      dec_c.amt   = {3'b000, in_ir[IR_ROT_HI:IR_ROT_LO], 1'b0};
      dec_c.stype = SH_ROR;
    end else begin
      dec_c.bypass = 1'b1;
    end
  end

  if (STAGES == 1) begin : g_one_stage
    assign core_op       = dec_c;
    assign core_carry_in = in_carry;
    assign core_valid    = in_valid;
    assign in_ready      = out_adv;
  end else begin : g_two_stage
    dec_op_t s1_op;
    logic    s1_carry;
    logic    s1_valid;

    always_ff @(posedge clk) begin
      if (reset) begin
        s1_valid <= 1'b0;
        s1_op    <= '0;
        s1_carry <= 1'b0;
      end else if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_op    <= dec_c;
          s1_carry <= in_carry;
        end
      end
    end

    assign in_ready      = !s1_valid || out_adv;
    assign core_op       = s1_op;
    assign core_carry_in = s1_carry;
    assign core_valid    = s1_valid;
  end

  shift_core #(.WIDTH(WIDTH)) u_core (
    .val      (core_op.val[WIDTH-1:0]),
    .amt      (core_op.amt),
    .stype    (core_op.stype),
    .rrx      (core_op.rrx),
    .carry_in (core_carry_in),
    .data_c   (core_data_c),
    .carry_c  (core_carry_c)
  );

  // Output stage: loads only when empty or drained, so a stalled result stays bit-stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_carry  <= 1'b0;
      out_bypass <= 1'b0;
    end else if (out_adv) begin
      out_valid <= core_valid;
      if (core_valid) begin
        out_data   <= core_data_c;
        out_carry  <= core_carry_c;
        out_bypass <= core_op.bypass;
      end
    end
  end

endmodule
